// File: rtl/spike_log_pkg.sv
// spike_log_pkg
//   Shared constants and event record for the spike event logger.
//   - *_DEF      : default parameter values for the logger top
//   - STATE_W    : width of the neuron membrane state field
//   - spike_evt_t: {ts_or_isi, state} record for the default widths
package spike_log_pkg;

  localparam int TS_W_DEF       = 8;
  localparam int DEPTH_DEF      = 8;
  localparam int WIN_CYCLES_DEF = 256;
  localparam int RATE_W_DEF     = 8;
  localparam int STATE_W        = 8;

  typedef struct packed {
    logic [TS_W_DEF-1:0] ts_or_isi;
    logic [STATE_W-1:0]  state;
  } spike_evt_t;

endpackage

// File: rtl/spike_evt_fifo.sv
// spike_evt_fifo
//   Synchronous FIFO for captured spike events.
//   Ports:
//     clk, rst_n  : clock, async active-low reset
//     push, din   : write request and data (accepted when not full, or
//                   when full and a pop happens in the same cycle)
//     pop         : read request (ignored when empty)
//     dout        : head entry, driven straight from storage flops
//     full, empty : occupancy flags
//     count       : registered occupancy
module spike_evt_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the one being popped this cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  assign dout  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/spike_event_logger.sv
// spike_event_logger
//   Tags each sampled neuron spike with a timestamp (or inter-spike
//   interval) and the membrane state, buffers it in a FIFO drained over a
//   valid/ready port, and reports a per-window spike rate.
//   Build option: define SPIKE_LOG_ISI_EN to carry the inter-spike interval
//   instead of the absolute timestamp in the ts_or_isi field.
//   Ports:
//     clk, rst_n            : clock, async active-low reset
//     en                    : capture enable (low freezes counters/pushes)
//     spike, state          : neuron spike and membrane state
//     evt_valid/ready/data  : FIFO head, {ts_or_isi, state}
//     fifo_count            : registered occupancy
//     overflow, ovf_clr     : sticky drop flag and its clear
//     rate, rate_valid      : last window spike count and update pulse
module spike_event_logger
  import spike_log_pkg::*;
#(
  parameter int TS_W       = TS_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int WIN_CYCLES = WIN_CYCLES_DEF,
  parameter int RATE_W     = RATE_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      spike,
  input  logic [STATE_W-1:0]        state,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [TS_W+STATE_W-1:0]   evt_data,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      overflow,
  input  logic                      ovf_clr,
  output logic [RATE_W-1:0]         rate,
  output logic                      rate_valid
);

  localparam int WIN_W = $clog2(WIN_CYCLES);

  logic             capture;
  logic             pop;
  logic             full;
  logic             empty;
  logic             drop;
  logic [TS_W-1:0]  ts_field;

  assign capture = en && spike;
  assign pop     = evt_valid && evt_ready;
  assign drop    = capture && full && !pop;

`ifdef SPIKE_LOG_ISI_EN
  // Holds enabled cycles since the last captured spike; starts saturated so
  // the first spike after reset reports the maximum interval.
  logic [TS_W-1:0] isi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_q <= '1;
    end else if (en) begin
      if (spike)              isi_q <= TS_W'(1);
      else if (isi_q != '1)   isi_q <= isi_q + 1'b1;
    end
  end

  assign ts_field = isi_q;
`else
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ts_q <= '0;
    else if (en) ts_q <= ts_q + 1'b1;
  end

  assign ts_field = ts_q;
`endif

  spike_evt_fifo #(
    .W     (TS_W + STATE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture),
    .din   ({ts_field, state}),
    .pop   (pop),
    .dout  (evt_data),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign evt_valid = !empty;

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  logic [WIN_W-1:0]  win_q;
  logic [RATE_W-1:0] spk_q;
  logic [RATE_W-1:0] spk_next;
  logic              win_last;

  assign win_last = (win_q == WIN_W'(WIN_CYCLES - 1));
  assign spk_next = (spike && (spk_q != '1)) ? spk_q + 1'b1 : spk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q      <= '0;
      spk_q      <= '0;
      rate       <= '0;
      rate_valid <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      if (en) begin
        if (win_last) begin
          win_q      <= '0;
          spk_q      <= '0;
          rate       <= spk_next;
          rate_valid <= 1'b1;
        end else begin
          win_q <= win_q + 1'b1;
          spk_q <= spk_next;
        end
      end
    end
  end

endmodule
